sdram_read_arbiter: RTL and testbench

//  N-channel Avalon-MM burst-read arbiter. Merges N_CH fetcher-style read masters onto one SDRAM

---
 rtl/sdram_read_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arbiter.sv
// N-channel round-robin burst-read arbiter onto a single SDRAM Avalon-MM read port.
// Optional performance counters are built when SDRAM_RD_ARB_PERF_EN is defined.
module sdram_read_arbiter #(
  parameter int N_CH         = 4,
  parameter int SDRAM_DATA_W = 128,
  parameter int SDRAM_ADDR_W = 32,
  parameter int BURST_W      = 11,
  parameter int MAX_OUTST    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                ch_read,
  input  logic [N_CH*SDRAM_ADDR_W-1:0]   ch_address,
  input  logic [N_CH*BURST_W-1:0]        ch_burstcount,
  output logic [N_CH-1:0]                ch_waitrequest,
  output logic [SDRAM_DATA_W-1:0]        ch_readdata,
  output logic [N_CH-1:0]                ch_readdatavalid,
  output logic                           m_read,
  output logic [SDRAM_ADDR_W-1:0]        m_address,
  output logic [BURST_W-1:0]             m_burstcount,
  input  logic                           m_waitrequest,
  input  logic [SDRAM_DATA_W-1:0]        m_readdata,
  input  logic                           m_readdatavalid,
  output logic                           err_unexpected
`ifdef SDRAM_RD_ARB_PERF_EN
  ,
  input  logic                           perf_clr,
  output logic [31:0]                    perf_stall,
  output logic [N_CH*32-1:0]             perf_beats
`endif
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [SDRAM_ADDR_W-1:0] addr_arr [N_CH];
  logic [BURST_W-1:0]      bc_arr   [N_CH];

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  scan;
  logic [CH_W-1:0]  grant_ch;
  logic             found;
  logic             grant_valid;
  logic             cmd_free;
  logic             credit_ok;
  logic [CNT_W:0]   occupied;
  logic [CH_W-1:0]  m_ch;

  logic [CH_W-1:0]    tag_ch [MAX_OUTST];
  logic [BURST_W-1:0] tag_bc [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   tag_count;
  logic [BURST_W-1:0] beats_done;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               beat_ok;
  logic [CH_W-1:0]    head_ch;
  logic [BURST_W-1:0] head_bc;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign addr_arr[gi] = ch_address[gi*SDRAM_ADDR_W +: SDRAM_ADDR_W];
      assign bc_arr[gi]   = ch_burstcount[gi*BURST_W +: BURST_W];
    end
  endgenerate

  // A command already sitting in the register counts against the in-flight limit.
  assign cmd_free  = !m_read || !m_waitrequest;
  assign occupied  = {1'b0, tag_count} + {{CNT_W{1'b0}}, m_read};
  assign credit_ok = occupied < (CNT_W+1)'(MAX_OUTST);

  // Round-robin scan starting just after the most recent grant.
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    scan     = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan = CH_W'((int'(rr_ptr) + k) % N_CH);
      if (!found && ch_read[scan]) begin
        found    = 1'b1;
        grant_ch = scan;
      end
    end
    grant_valid = found && cmd_free && credit_ok && rst_n;
  end

  always_comb begin
    ch_waitrequest = '1;
    if (grant_valid) ch_waitrequest[grant_ch] = 1'b0;
  end

  // Zero-length requests are acknowledged but never reach the SDRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_read       <= 1'b0;
      m_address    <= '0;
      m_burstcount <= '0;
      m_ch         <= '0;
      rr_ptr       <= '0;
    end else begin
      if (grant_valid) begin
        rr_ptr <= (grant_ch == CH_W'(N_CH-1)) ? '0 : grant_ch + 1'b1;
        if (bc_arr[grant_ch] != '0) begin
          m_read       <= 1'b1;
          m_address    <= addr_arr[grant_ch];
          m_burstcount <= bc_arr[grant_ch];
          m_ch         <= grant_ch;
        end else begin
          m_read <= 1'b0;
        end
      end else if (cmd_free) begin
        m_read <= 1'b0;
      end
    end
  end

  assign push       = m_read && !m_waitrequest;
  assign fifo_empty = (tag_count == '0);
  assign head_ch    = tag_ch[rd_ptr];
  assign head_bc    = tag_bc[rd_ptr];
  assign beat_ok    = m_readdatavalid && !fifo_empty;
  assign pop        = beat_ok && (beats_done == head_bc - 1'b1);

  always_ff @(posedge clk) begin
    if (push) begin
      tag_ch[wr_ptr] <= m_ch;
      tag_bc[wr_ptr] <= m_burstcount;
    end
  end

  // Tag FIFO bookkeeping; beats_done counts beats of the head burst seen so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      beats_done <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        beats_done <= '0;
      end else if (beat_ok) begin
        beats_done <= beats_done + 1'b1;
      end
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_unexpected <= 1'b0;
    else if (m_readdatavalid && fifo_empty)    err_unexpected <= 1'b1;
  end

  assign ch_readdata = m_readdata;

  always_comb begin
    ch_readdatavalid = '0;
    if (beat_ok) ch_readdatavalid[head_ch] = 1'b1;
  end

`ifdef SDRAM_RD_ARB_PERF_EN
  logic [31:0] beat_cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               perf_stall <= '0;
    else if (perf_clr)                                        perf_stall <= '0;
    else if (m_read && m_waitrequest && (perf_stall != '1))   perf_stall <= perf_stall + 1'b1;
  end

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_perf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          beat_cnt[gi] <= '0;
        else if (perf_clr)                                   beat_cnt[gi] <= '0;
        else if (ch_readdatavalid[gi] && (beat_cnt[gi] != '1)) beat_cnt[gi] <= beat_cnt[gi] + 1'b1;
      end
      assign perf_beats[gi*32 +: 32] = beat_cnt[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Randomized scoreboard bench for sdram_read_arbiter: transaction-level model of
// arbitration, credit limit and in-order beat routing.
module tb_sdram_read_arbiter;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int BURST_W   = 11;
  localparam int MAX_OUTST = 8;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    int          bc;
  } cmd_t;

  typedef struct {
    int           ch;
    logic [127:0] data;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_CH-1:0]           ch_read;
  logic [N_CH*ADDR_W-1:0]    ch_address;
  logic [N_CH*BURST_W-1:0]   ch_burstcount;
  logic [N_CH-1:0]           ch_waitrequest;
  logic [DATA_W-1:0]         ch_readdata;
  logic [N_CH-1:0]           ch_readdatavalid;
  logic                      m_read;
  logic [ADDR_W-1:0]         m_address;
  logic [BURST_W-1:0]        m_burstcount;
  logic                      m_waitrequest;
  logic [DATA_W-1:0]         m_readdata;
  logic                      m_readdatavalid;
  logic                      err_unexpected;
`ifdef SDRAM_RD_ARB_PERF_EN
  logic                      perf_clr = 1'b0;
  logic [31:0]               perf_stall;
  logic [N_CH*32-1:0]        perf_beats;
`endif

  int errors = 0;
  int checks = 0;

  cmd_t  req_q[$];
  cmd_t  cmd_q[$];
  cmd_t  slave_q[$];
  beat_t beat_q[$];

  bit mon_en = 1'b0;
  bit force_wait = 1'b0;
  bit rand_wait = 1'b0;
  bit ret_en = 1'b1;
  bit spurious = 1'b0;
  bit rdv_last = 1'b0;
  bit model_err = 1'b0;
  bit acc [N_CH];
  int ret_prob = 100;
  int load = 0;
  int gen_mode = 0;
  int s_idx = 0;
  int rr = 0;
  int model_outst = 0;

  sdram_read_arbiter #(
    .N_CH(N_CH), .SDRAM_DATA_W(DATA_W), .SDRAM_ADDR_W(ADDR_W),
    .BURST_W(BURST_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_read(ch_read),
    .ch_address(ch_address),
    .ch_burstcount(ch_burstcount),
    .ch_waitrequest(ch_waitrequest),
    .ch_readdata(ch_readdata),
    .ch_readdatavalid(ch_readdatavalid),
    .m_read(m_read),
    .m_address(m_address),
    .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_unexpected(err_unexpected)
`ifdef SDRAM_RD_ARB_PERF_EN
    ,
    .perf_clr(perf_clr),
    .perf_stall(perf_stall),
    .perf_beats(perf_beats)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat_data(input logic [31:0] addr, input int b);
    logic [31:0] bb;
    bb = 32'(b);
    return {addr, bb, addr ^ 32'hDEAD_BEEF, bb * 32'h9E37_79B9};
  endfunction

  task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic [31:0] addr, input int bc);
    cmd_t c;
    c.ch = ch;
    c.addr = addr;
    c.bc = bc;
    req_q.push_back(c);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Channel masters: hold each request until the arbiter acknowledges it.
  initial begin
    cmd_t c;
    bit   got;
    ch_read = '0;
    ch_address = '0;
    ch_burstcount = '0;
    for (int i = 0; i < N_CH; i++) acc[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ch_read = '0;
        for (int i = 0; i < N_CH; i++) acc[i] = 1'b0;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (acc[i]) begin
            acc[i] = 1'b0;
            ch_read[i] = 1'b0;
          end
        end
        for (int i = 0; i < N_CH; i++) begin
          if (!ch_read[i]) begin
            if (gen_mode == 1)
              apply_stimulus(i, $urandom, 1);
            else if (gen_mode == 2 && $urandom_range(99) < load)
              apply_stimulus(i, $urandom, ($urandom_range(9) == 0) ? 0 : $urandom_range(8, 1));
            got = 1'b0;
            for (int j = 0; j < req_q.size(); j++) begin
              if (!got && req_q[j].ch == i) begin
                c = req_q[j];
                req_q.delete(j);
                got = 1'b1;
                ch_read[i] = 1'b1;
                ch_address[i*ADDR_W +: ADDR_W] = c.addr;
                ch_burstcount[i*BURST_W +: BURST_W] = 11'(c.bc);
              end
            end
          end
        end
      end
    end
  end

  // SDRAM slave model: optional stall, returns accepted bursts in order.
  initial begin
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      m_readdatavalid = 1'b0;
      rdv_last = 1'b0;
      if (!rst_n) begin
        s_idx = 0;
        m_waitrequest = 1'b0;
      end else begin
        m_waitrequest = force_wait || (rand_wait && $urandom_range(3) == 0);
        if (spurious) begin
          m_readdatavalid = 1'b1;
          m_readdata = {$urandom, $urandom, $urandom, $urandom};
          spurious = 1'b0;
        end else if (ret_en && slave_q.size() > 0 && $urandom_range(99) < ret_prob) begin
          m_readdatavalid = 1'b1;
          m_readdata = beat_data(slave_q[0].addr, s_idx);
          rdv_last = (s_idx == slave_q[0].bc - 1);
          if (rdv_last) begin
            void'(slave_q.pop_front());
            s_idx = 0;
          end else begin
            s_idx++;
          end
        end
      end
    end
  end

  // Request-side model: round-robin from the last grant, one command slot, MAX_OUTST credits.
  always @(negedge clk) begin
    logic [N_CH-1:0] exp_wr;
    bit    gv;
    int    g;
    cmd_t  c;
    beat_t bt;
    if (mon_en && rst_n) begin
      exp_wr = '1;
      gv = 1'b0;
      g = 0;
      if (ch_read != '0 && (cmd_q.size() == 0 || !m_waitrequest) && model_outst < MAX_OUTST) begin
        for (int k = 0; k < N_CH; k++) begin
          if (!gv && ch_read[(rr + k) % N_CH]) begin
            gv = 1'b1;
            g = (rr + k) % N_CH;
          end
        end
      end
      if (gv) exp_wr[g] = 1'b0;
      check_output("ch_waitrequest", 128'(ch_waitrequest), 128'(exp_wr));
      check_output("m_read", 128'(m_read), 128'(cmd_q.size() != 0));
      if (cmd_q.size() != 0) begin
        check_output("m_address", 128'(m_address), 128'(cmd_q[0].addr));
        check_output("m_burstcount", 128'(m_burstcount), 128'(cmd_q[0].bc));
      end
      if (cmd_q.size() != 0 && !m_waitrequest) begin
        c = cmd_q.pop_front();
        slave_q.push_back(c);
        for (int b = 0; b < c.bc; b++) begin
          bt.ch = c.ch;
          bt.data = beat_data(c.addr, b);
          beat_q.push_back(bt);
        end
      end
      if (m_readdatavalid && rdv_last) model_outst--;
      if (gv) begin
        rr = (g + 1) % N_CH;
        acc[g] = 1'b1;
        c.ch = g;
        c.addr = ch_address[g*ADDR_W +: ADDR_W];
        c.bc = int'(ch_burstcount[g*BURST_W +: BURST_W]);
        if (c.bc != 0) begin
          cmd_q.push_back(c);
          model_outst++;
        end
      end
    end
  end

  // Return-side monitor: every SDRAM beat must land on the owner of the oldest burst.
  always @(negedge clk) begin
    beat_t b;
    if (mon_en && rst_n) begin
      check_output("err_unexpected", 128'(err_unexpected), 128'(model_err));
      if (m_readdatavalid) begin
        if (beat_q.size() == 0) begin
          check_output("rdv_spurious", 128'(ch_readdatavalid), 128'(0));
          model_err = 1'b1;
        end else begin
          b = beat_q.pop_front();
          check_output("rdv_onehot", 128'(ch_readdatavalid), 128'(1) << b.ch);
          check_output("readdata", ch_readdata, b.data);
        end
      end else begin
        check_output("rdv_idle", 128'(ch_readdatavalid), 128'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    wait_cycles(3);
    check_output("rst_m_read", 128'(m_read), 128'(0));
    check_output("rst_m_address", 128'(m_address), 128'(0));
    check_output("rst_m_burstcount", 128'(m_burstcount), 128'(0));
    check_output("rst_ch_waitrequest", 128'(ch_waitrequest), 128'(4'hF));
    check_output("rst_ch_readdatavalid", 128'(ch_readdatavalid), 128'(0));
    check_output("rst_err", 128'(err_unexpected), 128'(0));
    rst_n = 1'b1;
    rr = 0;
    mon_en = 1'b1;

    apply_stimulus(0, 32'h100, 4);
    wait_cycles(15);
    apply_stimulus(1, 32'h2000, 3);
    apply_stimulus(2, 32'h3000, 2);
    wait_cycles(20);

    gen_mode = 1;
    wait_cycles(80);
    gen_mode = 2;
    load = 30;
    ret_prob = 70;
    wait_cycles(300);

    ret_en = 1'b0;
    load = 60;
    wait_cycles(60);
    ret_en = 1'b1;
    ret_prob = 100;
    wait_cycles(40);

    gen_mode = 1;
    wait_cycles(3);
    force_wait = 1'b1;
    wait_cycles(5);
    force_wait = 1'b0;
    wait_cycles(10);

    gen_mode = 2;
    load = 40;
    rand_wait = 1'b1;
    ret_prob = 60;
    wait_cycles(300);

    gen_mode = 0;
    rand_wait = 1'b0;
    n = 0;
    while (n < 3000 && !(cmd_q.size() == 0 && slave_q.size() == 0 && beat_q.size() == 0 &&
                         req_q.size() == 0 && ch_read == '0 && model_outst == 0)) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", 128'(n >= 3000), 128'(0));

    spurious = 1'b1;
    wait_cycles(3);
    check_output("err_set", 128'(err_unexpected), 128'(1));
    wait_cycles(5);
    check_output("err_sticky", 128'(err_unexpected), 128'(1));

    apply_stimulus(3, 32'h4000, 8);
    n = 0;
    while (n < 200 && s_idx == 0) begin
      @(negedge clk);
      n++;
    end
    check_output("burst_start_timeout", 128'(n >= 200), 128'(0));
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("midrst_m_read", 128'(m_read), 128'(0));
    check_output("midrst_rdv", 128'(ch_readdatavalid), 128'(0));
    check_output("midrst_err", 128'(err_unexpected), 128'(0));
    check_output("midrst_waitreq", 128'(ch_waitrequest), 128'(4'hF));
    req_q.delete();
    cmd_q.delete();
    slave_q.delete();
    beat_q.delete();
    model_outst = 0;
    model_err = 1'b0;
    rr = 0;
    wait_cycles(3);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cycles(2);

    spurious = 1'b1;
    wait_cycles(3);
    check_output("post_rst_err", 128'(err_unexpected), 128'(1));

    apply_stimulus(2, 32'h5000, 2);
    wait_cycles(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
